// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three buses around the shared program/data RAM:
//   the CPU request port, the program-loader (LD) request port and the RAM port.
//   Parameters: ADDR_W (RAM address width), DATA_W (RAM data width).
//   Modports:
//     slave  - the arbiter: takes CPU/LD requests and RAM read data, drives
//              completion pulses, read data, stall and the RAM controls.
//     master - the surrounding system (CPU, loader, RAM): the opposite view.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // CPU port
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;
  // Loader port
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_done;
  // RAM port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_done, cpu_stall,
    output ld_rdata, ld_done,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    input  ld_rdata, ld_done,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port RAM between the CPU control unit and the program
//   loader. One access at a time: IDLE picks an owner and latches its request,
//   ACCESS holds mem_en for MEM_LAT cycles (read data captured on the last
//   one), DONE gives the owner a one-cycle done pulse.
//   Parameters: ADDR_W, DATA_W, MEM_LAT (cycles mem_en is held, >= 1).
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous reset, active high (aborts any access, no done pulse)
//     bus  - mem_port_arbiter_if.slave (CPU port, LD port, RAM port)
//   Build option: ARB_ROUND_ROBIN_EN
//     defined   - on contention grant the port not granted last (a last-grant
//                 register resets to LD, so the CPU wins the first contention)
//     undefined - fixed priority, LD always beats CPU
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner_ld;   // 1: loader owns the current access
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ld_rdata;

  logic w_cpu_req;
  logic w_any_req;
  logic w_grant_ld;
  logic w_last_cycle;
  logic w_mem_en;
  logic w_mem_we;
  logic w_cpu_done;
  logic w_ld_done;

  assign w_cpu_req    = bus.cpu_read | bus.cpu_write;
  assign w_any_req    = w_cpu_req | bus.ld_req;
  assign w_last_cycle = (r_cnt == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_ld;   // 1: the most recent grant went to the loader
  // Loader wins if alone, or on contention when the CPU had the last grant.
  assign w_grant_ld = bus.ld_req & (~w_cpu_req | ~r_last_ld);
`else
  assign w_grant_ld = bus.ld_req;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner_ld  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_ld   <= 1'b1;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_any_req) begin
            r_owner_ld <= w_grant_ld;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_ld  <= w_grant_ld;
`endif
            if (w_grant_ld) begin
              r_we    <= bus.ld_we;
              r_addr  <= bus.ld_addr;
              r_wdata <= bus.ld_wdata;
            end else begin
              // read+write together is a write
              r_we    <= bus.cpu_write;
              r_addr  <= bus.cpu_addr;
              r_wdata <= bus.cpu_wdata;
            end
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last_cycle && !r_we) begin
            if (r_owner_ld) begin
              r_ld_rdata <= bus.mem_rdata;
            end else begin
              r_cpu_rdata <= bus.mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_next = S_ACCESS;
      S_ACCESS: if (w_last_cycle) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_mem_en   = 1'b0;
    w_mem_we   = 1'b0;
    w_cpu_done = 1'b0;
    w_ld_done  = 1'b0;
    case (r_state)
      S_ACCESS: begin
        w_mem_en = 1'b1;
        w_mem_we = r_we;
      end
      S_DONE: begin
        w_cpu_done = ~r_owner_ld;
        w_ld_done  = r_owner_ld;
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.cpu_done  = w_cpu_done;
  assign bus.ld_done   = w_ld_done;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.ld_rdata  = r_ld_rdata;
  // Stall drops in the done cycle so the CPU can advance on the same edge.
  assign bus.cpu_stall = w_cpu_req & ~w_cpu_done;

endmodule
